// File: rtl/piso_tx_sched.sv
// piso_tx_sched: word scheduler in front of the 10-bit PISO serializer.
// Every WORD_W+1 cycles one decision cycle picks ALIGN, DATA, CTRL or IDLE.
// The chosen word is presented on par_out with a one-cycle load_en strobe.
module piso_tx_sched #(
   parameter int                WORD_W       = 10,
   parameter logic [WORD_W-1:0] IDLE_WORD    = 10'h17C,
   parameter logic [WORD_W-1:0] ALIGN_WORD   = 10'h283,
   parameter int                ALIGN_PERIOD = 256,
   parameter int                CTRL_MAX_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [WORD_W-1:0] ctrl_in,
   input  logic              ctrl_valid,
   output logic              ctrl_ready,
   output logic [WORD_W-1:0] par_out,
   output logic              load_en,
   output logic [1:0]        word_sel
);

   localparam int CW = $clog2(WORD_W + 1);
   localparam int AW = (ALIGN_PERIOD > 2) ? $clog2(ALIGN_PERIOD) : 1;
   localparam int RW = (CTRL_MAX_RUN > 1) ? $clog2(CTRL_MAX_RUN + 1) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(WORD_W);
   // With forcing disabled the counter is pinned at 0 and never matches.
   localparam logic [AW-1:0] ALIGN_LAST = AW'((ALIGN_PERIOD > 0) ? ALIGN_PERIOD - 1 : 0);
   localparam logic [RW-1:0] RUN_MAX    = RW'(CTRL_MAX_RUN);
   localparam logic          ALIGN_ON   = (ALIGN_PERIOD != 0);

   typedef enum logic [1:0] {
      SEL_IDLE  = 2'b00,
      SEL_DATA  = 2'b01,
      SEL_CTRL  = 2'b10,
      SEL_ALIGN = 2'b11
   } sel_t;

   logic [CW-1:0]     slot_cnt;
   logic [AW-1:0]     align_cnt;
   logic [RW-1:0]     ctrl_run;
   logic              decision;
   logic              align_due;
   sel_t              sel;
   logic [WORD_W-1:0] word_nxt;

   assign decision  = !rst && (slot_cnt == CNT_LAST);
   assign align_due = ALIGN_ON && (align_cnt == ALIGN_LAST);

   // Source priority for the current slot; only meaningful in the decision cycle.
   always_comb begin
      sel      = SEL_IDLE;
      word_nxt = IDLE_WORD;
      if (align_due) begin
         sel      = SEL_ALIGN;
         word_nxt = ALIGN_WORD;
      end else if (data_valid && (ctrl_run == RUN_MAX)) begin
         sel      = SEL_DATA;
         word_nxt = data_in;
      end else if (ctrl_valid) begin
         sel      = SEL_CTRL;
         word_nxt = ctrl_in;
      end else if (data_valid) begin
         sel      = SEL_DATA;
         word_nxt = data_in;
      end
   end

   // Readies are combinational so a source word is taken in the same cycle it is chosen.
   assign data_ready = decision && (sel == SEL_DATA);
   assign ctrl_ready = decision && (sel == SEL_CTRL);

   // Slot counter and load strobe; reset parks the counter on the decision value.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= CNT_LAST;
         load_en  <= 1'b0;
      end else begin
         slot_cnt <= (slot_cnt == CNT_LAST) ? '0 : slot_cnt + CW'(1);
         load_en  <= decision;
      end
   end

   // Output word register; holds its value between loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_out  <= '0;
         word_sel <= 2'b00;
      end else if (decision) begin
         par_out  <= word_nxt;
         word_sel <= sel;
      end
   end

   // Alignment spacing and control-burst bookkeeping, advanced once per slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         align_cnt <= '0;
         ctrl_run  <= '0;
      end else if (decision) begin
         if ((sel == SEL_ALIGN) || (sel == SEL_IDLE)) begin
            align_cnt <= '0;
         end else if (align_cnt != ALIGN_LAST) begin
            align_cnt <= align_cnt + AW'(1);
         end
         if (sel == SEL_CTRL) begin
            if (ctrl_run != RUN_MAX) begin
               ctrl_run <= ctrl_run + RW'(1);
            end
         end else begin
            ctrl_run <= '0;
         end
      end
   end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched: three instances cover the default setup,
// a short control-burst limit and a short alignment period.
module tb_piso_tx_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] data_in;
   logic [9:0] ctrl_in;
   logic       data_valid;
   logic       ctrl_valid;

   logic       dr [3];
   logic       cr [3];
   logic       le [3];
   logic [9:0] po [3];
   logic [1:0] ws [3];

   int         total = 0;
   int         bad   = 0;
   logic [1:0] exp_seq [16];

   always #5 clk = ~clk;

   piso_tx_sched u_def (
      .clk(clk), .rst(rst),
      .data_in(data_in), .data_valid(data_valid), .data_ready(dr[0]),
      .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid), .ctrl_ready(cr[0]),
      .par_out(po[0]), .load_en(le[0]), .word_sel(ws[0])
   );

   piso_tx_sched #(.CTRL_MAX_RUN(2)) u_run2 (
      .clk(clk), .rst(rst),
      .data_in(data_in), .data_valid(data_valid), .data_ready(dr[1]),
      .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid), .ctrl_ready(cr[1]),
      .par_out(po[1]), .load_en(le[1]), .word_sel(ws[1])
   );

   piso_tx_sched #(.ALIGN_PERIOD(4)) u_al4 (
      .clk(clk), .rst(rst),
      .data_in(data_in), .data_valid(data_valid), .data_ready(dr[2]),
      .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid), .ctrl_ready(cr[2]),
      .par_out(po[2]), .load_en(le[2]), .word_sel(ws[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [9:0] word_of(input logic [1:0] s);
      case (s)
         2'b00:   word_of = 10'h17C;
         2'b01:   word_of = 10'h155;
         2'b10:   word_of = 10'h2AA;
         default: word_of = 10'h283;
      endcase
   endfunction

   // Hold reset three cycles with the given valids, check reset state, release.
   // Returns inside cycle 0 (the first decision cycle), before its rising edge.
   task automatic do_reset(input int w, input logic dv, input logic cv);
      @(negedge clk);
      rst        = 1'b1;
      data_valid = dv;
      ctrl_valid = cv;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_load_en",    32'(le[w]), 32'(0));
      chk("rst_par_out",    32'(po[w]), 32'(0));
      chk("rst_word_sel",   32'(ws[w]), 32'(0));
      chk("rst_data_ready", 32'(dr[w]), 32'(0));
      chk("rst_ctrl_ready", 32'(cr[w]), 32'(0));
      rst = 1'b0;
   endtask

   // Run n slots on instance w against exp_seq; data_valid is dropped only in
   // the decision cycle of slot drop_slot (-1 for never).
   task automatic run_slots(input int w, input int n, input logic dv, input logic cv,
                            input int drop_slot);
      int k;
      do_reset(w, dv, cv);
      for (int c = 0; c <= 11 * (n - 1) + 1; c++) begin
         data_valid = (c == 11 * drop_slot) ? 1'b0 : dv;
         ctrl_valid = cv;
         #1;
         if (c % 11 == 0) begin
            k = c / 11;
            chk("dec_data_ready", 32'(dr[w]), 32'(exp_seq[k] == 2'b01));
            chk("dec_ctrl_ready", 32'(cr[w]), 32'(exp_seq[k] == 2'b10));
            chk("dec_load_en",    32'(le[w]), 32'(0));
         end else if (c % 11 == 1) begin
            k = (c - 1) / 11;
            chk("ld_load_en",  32'(le[w]), 32'(1));
            chk("ld_word_sel", 32'(ws[w]), 32'(exp_seq[k]));
            chk("ld_par_out",  32'(po[w]), 32'(word_of(exp_seq[k])));
         end else begin
            chk("sh_load_en",    32'(le[w]), 32'(0));
            chk("sh_data_ready", 32'(dr[w]), 32'(0));
            chk("sh_ctrl_ready", 32'(cr[w]), 32'(0));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int hs;
      int ld;
      data_in    = 10'h155;
      ctrl_in    = 10'h2AA;
      data_valid = 1'b0;
      ctrl_valid = 1'b0;

      // Idle only
      for (int i = 0; i < 16; i++) exp_seq[i] = 2'b00;
      run_slots(0, 4, 1'b0, 1'b0, -1);

      // Continuous data
      for (int i = 0; i < 16; i++) exp_seq[i] = 2'b01;
      run_slots(0, 3, 1'b1, 1'b0, -1);

      // Control burst limit of 2 with both sources valid
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
      exp_seq[3] = 2'b10; exp_seq[4] = 2'b10; exp_seq[5] = 2'b01;
      run_slots(1, 6, 1'b1, 1'b1, -1);

      // Forced alignment every 4 slots
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b11;
      exp_seq[4] = 2'b01; exp_seq[5] = 2'b01; exp_seq[6] = 2'b01; exp_seq[7] = 2'b11;
      run_slots(2, 8, 1'b1, 1'b0, -1);

      // Valid dropped in a decision cycle: idle slot restarts the alignment spacing
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b00; exp_seq[3] = 2'b01;
      exp_seq[4] = 2'b01; exp_seq[5] = 2'b01; exp_seq[6] = 2'b11; exp_seq[7] = 2'b01;
      run_slots(2, 8, 1'b1, 1'b0, 2);

      // One-cycle reset in the middle of a slot with data held valid
      data_in = 10'h0AB;
      do_reset(0, 1'b1, 1'b0);
      hs = 0;
      ld = 0;
      for (int c = 0; c <= 30; c++) begin
         rst = (c == 6);
         #1;
         if (c == 6) begin
            chk("t5_rst_ready",   32'(dr[0]), 32'(0));
            chk("t5_rst_load_en", 32'(le[0]), 32'(0));
         end
         if (c == 7) begin
            chk("t5_dec_load_en", 32'(le[0]), 32'(0));
            chk("t5_dec_ready",   32'(dr[0]), 32'(1));
         end
         if (c == 8) begin
            chk("t5_ld_load_en", 32'(le[0]), 32'(1));
            chk("t5_ld_par_out", 32'(po[0]), 32'(10'h0AB));
         end
         if (data_valid && dr[0]) hs++;
         if (le[0] && (ws[0] == 2'b01)) ld++;
         @(negedge clk);
      end
      chk("t5_handshakes", 32'(hs), 32'(4));
      chk("t5_data_loads", 32'(ld), 32'(4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
